// File: rtl/conv_kxk_mac_pipe.sv
// KxK convolution MAC engine: per-channel weight banks, 3-stage product / adder-tree / accumulate
// pipeline producing one output pixel per CH accepted input windows.
module conv_kxk_mac_pipe #(
    parameter  int DW     = 8,
    parameter  int K      = 3,
    parameter  int CH     = 1,
    parameter  int SIGNED = 0,
    localparam int N      = K * K,
    localparam int OW     = 2 * DW + $clog2(N * CH) + SIGNED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              weight_valid,
    input  logic [N*DW-1:0]   In_Weight,
    input  logic              in_valid,
    input  logic [N*DW-1:0]   In_IFM,
    input  logic              acc_clr,
    output logic              wt_ready,
    output logic              out_valid,
    output logic [OW-1:0]     Out_OFM
);

    localparam int            PW      = (CH > 1) ? $clog2(CH) : 1;
    localparam int            PROD_W  = 2 * DW;
    localparam logic [PW-1:0] LAST_CH = PW'(CH - 1);

    // Sign- or zero-extend both operands to the product width so one unsigned
    // multiply yields the correct low 2*DW bits in either mode.
    function automatic logic [PROD_W-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [PROD_W-1:0] ae;
        logic [PROD_W-1:0] be;
        ae      = {{DW{(SIGNED != 0) && a[DW-1]}}, a};
        be      = {{DW{(SIGNED != 0) && b[DW-1]}}, b};
        mul_ext = ae * be;
    endfunction

    function automatic logic [OW-1:0] ext_ow(input logic [PROD_W-1:0] p);
        logic [OW-1:0] r;
        r               = {OW{(SIGNED != 0) && p[PROD_W-1]}};
        r[PROD_W-1:0]   = p;
        ext_ow          = r;
    endfunction

    // ---------------------------------------------------------------- state
    logic [N*DW-1:0]   bank_q [CH];
    logic [N*DW-1:0]   bank_d [CH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     cptr_q, cptr_d;
    logic              wt_ready_q, wt_ready_d;

    logic [PROD_W-1:0] prod_q [N];
    logic [PROD_W-1:0] prod_d [N];
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;

    logic [OW-1:0]     sum_q, sum_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q, s2_last_d;

    logic [OW-1:0]     acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [OW-1:0]     ofm_q, ofm_d;

    logic              accept;
    logic [N*DW-1:0]   sel_w;

    // ---------------------------------------------------------------- weight load / channel pointer
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bank_d     = bank_q;
        wptr_d     = wptr_q;
        wt_ready_d = wt_ready_q;
        cptr_d     = cptr_q;
        accept     = in_valid && wt_ready_q && !acc_clr;

        if (weight_valid) begin
            bank_d[wptr_q] = In_Weight;
            wptr_d         = (wptr_q == LAST_CH) ? '0 : wptr_q + 1'b1;
            if (wptr_q == LAST_CH) begin
                wt_ready_d = 1'b1;
            end
        end

        if (acc_clr) begin
            cptr_d = '0;
        end else if (accept) begin
            cptr_d = (cptr_q == LAST_CH) ? '0 : cptr_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- S1: element products
    // bank_q is read here before this edge's write lands, giving read-before-write on a shared edge.
    always_comb begin
        sel_w      = bank_q[cptr_q];
        prod_d     = prod_q;
        s1_valid_d = accept;
        s1_last_d  = s1_last_q;
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                prod_d[i] = mul_ext(In_IFM[i*DW +: DW], sel_w[i*DW +: DW]);
            end
            s1_last_d = (cptr_q == LAST_CH);
        end
    end

    // ---------------------------------------------------------------- S2: adder tree
    always_comb begin
        sum_d      = sum_q;
        s2_valid_d = s1_valid_q && !acc_clr;
        s2_last_d  = s2_last_q;
        if (s1_valid_q) begin
            sum_d = '0;
            for (int i = 0; i < N; i++) begin
                sum_d = sum_d + ext_ow(prod_q[i]);
            end
            s2_last_d = s1_last_q;
        end
    end

    // ---------------------------------------------------------------- S3: channel accumulate / emit
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        ofm_d       = '0;
        if (acc_clr) begin
            acc_d = '0;
        end else if (s2_valid_q) begin
            if (s2_last_q) begin
                out_valid_d = 1'b1;
                ofm_d       = acc_q + sum_q;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + sum_q;
            end
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the weight banks are a register file with a real reset; a reset clears them and forces a reload.
            for (int c = 0; c < CH; c++) begin
                bank_q[c] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                prod_q[i] <= '0;
            end
            wptr_q      <= '0;
            cptr_q      <= '0;
            wt_ready_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            sum_q       <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            ofm_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous cycle's values.
            bank_q      <= bank_d;
            prod_q      <= prod_d;
            wptr_q      <= wptr_d;
            cptr_q      <= cptr_d;
            wt_ready_q  <= wt_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            sum_q       <= sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            ofm_q       <= ofm_d;
        end
    end

    assign wt_ready  = wt_ready_q;
    assign out_valid = out_valid_q;
    assign Out_OFM   = ofm_q;

endmodule
